vector_alu_pipe: RTL and testbench



---
 rtl/vector_alu_pipe.sv | 108 ++++++++++
 tb/tb_vector_alu_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: sequential vector ALU with single-cycle lane/scalar ops and iterated VDOT/SMUL.
// Define VECTOR_ALU_SAT_EN for signed saturation of VADD, SMUL and the VDOT sum.
module vector_alu_pipe #(
    parameter int LANES = 16,
    parameter int LANE_W = 16,
    parameter int MACS_PER_CYC = 1,
    localparam int DATA_W = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] op_1,
    input  logic [DATA_W-1:0] op_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);
    localparam int IW = $clog2(LANES);
    localparam logic [3:0] OP_VADD = 4'd0, OP_VDOT = 4'd1, OP_SMUL = 4'd2, OP_SST = 4'd3;
    localparam logic [3:0] OP_VLD = 4'd4, OP_VST = 4'd5, OP_SLL = 4'd6, OP_SLH = 4'd7;
`ifdef VECTOR_ALU_SAT_EN
    localparam int FW = 2 * LANE_W + IW;
    localparam int PW = 2 * LANE_W;
    localparam logic signed [FW-1:0] SMAX = (FW'(1) <<< (LANE_W - 1)) - FW'(1);
    localparam logic signed [FW-1:0] SMIN = -(FW'(1) <<< (LANE_W - 1));
    function automatic logic [LANE_W-1:0] fit(input logic signed [FW-1:0] v);
        return v > SMAX ? SMAX[LANE_W-1:0] : v < SMIN ? SMIN[LANE_W-1:0] : v[LANE_W-1:0];
    endfunction
`else
    localparam int FW = LANE_W;
    localparam int PW = LANE_W;
    function automatic logic [LANE_W-1:0] fit(input logic signed [FW-1:0] v);
        return v;
    endfunction
`endif
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] opc;
    logic [DATA_W-1:0] a, b, b_nxt, vadd, fast, res_nxt;
    logic signed [FW-1:0] acc, acc_nxt;
    logic signed [PW-1:0] prod;
    logic [IW-1:0] cnt, idx;
    logic [15:0] addr;
    logic mc, fin;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign mc = opc == OP_VDOT || opc == OP_SMUL;
    assign fin = !mc || cnt == IW'(LANES - MACS_PER_CYC);
    assign addr = a[15:0] + b[15:0];
    for (genvar i = 0; i < LANES; i++) begin : g_vadd
        assign vadd[LANE_W*i +: LANE_W] =
            fit(FW'($signed(a[LANE_W*i +: LANE_W])) + FW'($signed(b[LANE_W*i +: LANE_W])));
    end
    assign fast = opc == OP_VADD ? vadd :
                  opc inside {OP_SST, OP_VLD, OP_VST} ? DATA_W'(addr) :
                  opc == OP_SLL ? DATA_W'({a[15:8], b[7:0]}) :
                  opc == OP_SLH ? DATA_W'({b[7:0], a[7:0]}) : '0;
    always_comb begin
        state_nxt = state == IDLE ? (in_valid ? EXEC : IDLE) :
                    state == EXEC ? (fin ? DONE : EXEC) :
                    (out_ready ? IDLE : DONE);
    end
    // SMUL products overwrite the consumed lanes of b so no extra work register is needed
    always_comb begin
        acc_nxt = acc;
        b_nxt = b;
        idx = cnt;
        prod = '0;
        for (int j = 0; j < MACS_PER_CYC; j++) begin
            idx = cnt + IW'(j);
            prod = PW'($signed(opc == OP_SMUL ? a[LANE_W-1:0] : a[LANE_W*idx +: LANE_W])) *
                   PW'($signed(b[LANE_W*idx +: LANE_W]));
            acc_nxt = acc_nxt + FW'(prod);
            b_nxt[LANE_W*idx +: LANE_W] = fit(FW'(prod));
        end
        res_nxt = opc == OP_SMUL ? b_nxt : opc == OP_VDOT ? DATA_W'(fit(acc_nxt)) : fast;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opc <= '0;
            a <= '0;
            b <= '0;
            acc <= '0;
            cnt <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                opc <= opcode;
                a <= op_1;
                b <= op_2;
                acc <= '0;
                cnt <= '0;
            end
            if (state == EXEC) begin
                acc <= acc_nxt;
                b <= b_nxt;
                cnt <= cnt + IW'(MACS_PER_CYC);
                if (fin) result <= res_nxt;
            end
        end
    end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb_vector_alu_pipe: randomized self-checking bench for vector_alu_pipe against a lane-level arithmetic model.
module tb_vector_alu_pipe;
    localparam int LANES = 16;
    localparam int LANE_W = 16;
    localparam int MACS = 1;
    localparam int DATA_W = LANES * LANE_W;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, busy;
    logic [3:0] opcode = 0;
    logic [DATA_W-1:0] op_1 = 0, op_2 = 0, result;
    int total = 0, bad = 0;
    vector_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .MACS_PER_CYC(MACS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .op_1(op_1), .op_2(op_2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic longint ln(input logic [DATA_W-1:0] v, input int i);
        return longint'($signed(v[i*LANE_W +: LANE_W]));
    endfunction
    function automatic logic [LANE_W-1:0] clamp(input longint v);
        longint t = v;
`ifdef VECTOR_ALU_SAT_EN
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`endif
        return t[LANE_W-1:0];
    endfunction
    function automatic logic [DATA_W-1:0] model(input logic [3:0] op, input logic [DATA_W-1:0] x, y);
        logic [DATA_W-1:0] r = '0;
        logic [15:0] s16;
        longint s = 0;
        case (op)
            4'd0: for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = clamp(ln(x, i) + ln(y, i));
            4'd1: begin
                for (int i = 0; i < LANES; i++) s += ln(x, i) * ln(y, i);
                r[LANE_W-1:0] = clamp(s);
            end
            4'd2: for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = clamp(ln(x, 0) * ln(y, i));
            4'd3, 4'd4, 4'd5: begin
                s16 = x[15:0] + y[15:0];
                r[15:0] = s16;
            end
            4'd6: r[15:0] = {x[15:8], y[7:0]};
            4'd7: r[15:0] = {y[7:0], x[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction
    function automatic int exp_lat(input logic [3:0] op);
        return (op == 4'd1 || op == 4'd2) ? LANES / MACS : 1;
    endfunction
    function automatic logic [DATA_W-1:0] rnd();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction
    function automatic logic [DATA_W-1:0] splat(input logic [LANE_W-1:0] x);
        logic [DATA_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = x;
        return v;
    endfunction
    // Drives one transaction, scrambles inputs after acceptance, returns result and latency.
    task automatic run(input logic [3:0] op, input logic [DATA_W-1:0] x, y,
                       output logic [DATA_W-1:0] r, output int lat);
        @(negedge clk);
        opcode = op; op_1 = x; op_2 = y; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0; opcode = 4'($urandom); op_1 = rnd(); op_2 = rnd();
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        r = result;
        @(negedge clk) out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask
    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        rst = 0;
    endtask
    task automatic check_op(input string nm, input logic [3:0] op, input logic [DATA_W-1:0] x, y);
        logic [DATA_W-1:0] r, e;
        int lat;
        e = model(op, x, y);
        run(op, x, y, r, lat);
        total++; if (r !== e) begin bad++; $display("FAIL %s op=%h got=%h want=%h", nm, op, r, e); end
        total++; if (lat !== exp_lat(op)) begin bad++; $display("FAIL %s_latency op=%h got=%0d want=%0d", nm, op, lat, exp_lat(op)); end
    endtask
    task automatic test_vadd();
        logic [DATA_W-1:0] x = rnd(), y = rnd();
        x[31:0] = {16'h0003, 16'h7FFF};
        y[31:0] = {16'hFFFF, 16'h0001};
        check_op("vadd_edge", 4'd0, x, y);
        for (int k = 0; k < 4; k++) check_op("vadd_rand", 4'd0, rnd(), rnd());
    endtask
    task automatic test_vdot();
        logic [DATA_W-1:0] y, r;
        int lat;
        for (int i = 0; i < LANES; i++) y[i*LANE_W +: LANE_W] = LANE_W'(i);
        run(4'd1, splat(16'd2), y, r, lat);
        total++; if (r !== DATA_W'(16'h00F0)) begin bad++; $display("FAIL vdot_ramp got=%h want=f0", r); end
        total++; if (lat !== LANES / MACS) begin bad++; $display("FAIL vdot_ramp_latency got=%0d want=%0d", lat, LANES / MACS); end
        for (int k = 0; k < 4; k++) check_op("vdot_rand", 4'd1, rnd(), rnd());
    endtask
    task automatic test_smul();
        check_op("smul_edge", 4'd2, splat(16'd3), splat(16'h6000));
        for (int k = 0; k < 3; k++) check_op("smul_rand", 4'd2, rnd(), rnd());
    endtask
    task automatic test_scalar();
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] want [4] = '{DATA_W'(16'h12AB), DATA_W'(16'hAB34), DATA_W'(16'h12DF), '0};
        logic [3:0] ops [4] = '{4'd6, 4'd7, 4'd4, 4'd15};
        int lat;
        for (int k = 0; k < 4; k++) begin
            run(ops[k], DATA_W'(16'h1234), DATA_W'(16'h00AB), r, lat);
            total++; if (r !== want[k]) begin bad++; $display("FAIL scalar op=%h got=%h want=%h", ops[k], r, want[k]); end
        end
        for (int k = 0; k < 12; k++) check_op("any_rand", 4'($urandom), rnd(), rnd());
    endtask
    task automatic test_backpressure();
        logic [DATA_W-1:0] x = rnd(), y = rnd(), held;
        int n = 0;
        @(negedge clk);
        opcode = 4'd0; op_1 = x; op_2 = y; in_valid = 1;
        @(posedge clk);
        #1 opcode = 4'd1; op_1 = rnd();
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        held = result;
        total++; if (held !== model(4'd0, x, y)) begin bad++; $display("FAIL bp_result got=%h want=%h", held, model(4'd0, x, y)); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) begin
                bad++; $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b res=%h want 1 0 %h", k, out_valid, in_ready, result, held);
            end
        end
        @(negedge clk);
        out_ready = 1; in_valid = 0;
        @(posedge clk);
        #1 out_ready = 0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_release got ready=%b valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask
    task automatic test_reset_mid();
        logic [DATA_W-1:0] r;
        int lat;
        @(negedge clk);
        opcode = 4'd1; op_1 = rnd(); op_2 = rnd(); in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (7) @(posedge clk);
        #2 total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst = 1;
        #1 total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset got valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
        end
        @(negedge clk) rst = 0;
        run(4'd0, splat(16'd1), splat(16'd1), r, lat);
        total++; if (r !== splat(16'd2)) begin bad++; $display("FAIL mid_vadd got=%h want=%h", r, splat(16'd2)); end
    endtask
    task automatic test_back_to_back();
        logic [DATA_W-1:0] x = rnd(), y = rnd();
        int acc_n = 0, done_n = 0;
        @(negedge clk);
        opcode = 4'd0; op_1 = x; op_2 = y; in_valid = 1; out_ready = 1;
        for (int k = 0; k < 30; k++) begin
            if (in_ready) acc_n++;
            if (out_valid) begin
                done_n++;
                total++; if (result !== model(4'd0, x, y)) begin bad++; $display("FAIL b2b_result got=%h want=%h", result, model(4'd0, x, y)); end
            end
            @(negedge clk);
        end
        in_valid = 0; out_ready = 0;
        total++; if (acc_n !== 10 || done_n !== 10) begin bad++; $display("FAIL b2b_rate got accepts=%0d dones=%0d want 10 10", acc_n, done_n); end
    endtask
    initial begin
        test_reset();
        test_vadd();
        test_vdot();
        test_smul();
        test_scalar();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
